// File: rtl/divn_pkg.sv
// divn_pkg: shared definitions for the peripheral_divn register map and control FSM.
//   Register indices (addr[4:2]), CTRL/STATUS bit positions, FSM state encoding.
package divn_pkg;

    localparam logic [2:0] REG_DIVIDEND  = 3'd0;
    localparam logic [2:0] REG_DIVISOR   = 3'd1;
    localparam logic [2:0] REG_CTRL      = 3'd2;
    localparam logic [2:0] REG_STATUS    = 3'd3;
    localparam logic [2:0] REG_QUOTIENT  = 3'd4;
    localparam logic [2:0] REG_REMAINDER = 3'd5;

    localparam int unsigned CTRL_START  = 0;
    localparam int unsigned CTRL_SIGNED = 1;
    localparam int unsigned CTRL_IRQ_EN = 2;

    localparam int unsigned STAT_BUSY     = 0;
    localparam int unsigned STAT_DONE     = 1;
    localparam int unsigned STAT_DIV_ZERO = 2;
    localparam int unsigned STAT_OVF      = 3;

    typedef enum logic [1:0] {
        StIdle,
        StPrep,
        StIter,
        StFix
    } divn_state_e;

endpackage

// File: rtl/peripheral_divn_if.sv
// peripheral_divn_if: FemtoRV32 I/O bus slice seen by the divider peripheral.
//   cs/addr/rd/wr/d_in : driven by the bus master
//   d_out/irq          : driven by the peripheral
interface peripheral_divn_if;

    logic        cs;
    logic [4:0]  addr;
    logic        rd;
    logic        wr;
    logic [31:0] d_in;
    logic [31:0] d_out;
    logic        irq;

    modport master (
        output cs, addr, rd, wr, d_in,
        input  d_out, irq
    );

    modport slave (
        input  cs, addr, rd, wr, d_in,
        output d_out, irq
    );

endinterface

// File: rtl/divn_core.sv
// divn_core: unsigned restoring divider, one quotient bit per clock.
//   clk, reset : clock, asynchronous active-high reset
//   load       : capture a (dividend) and b (divisor) and start iterating
//   q, r       : quotient / remainder, valid the cycle after last
//   last       : high during the cycle whose edge produces the final bit
module divn_core #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] r,
    output logic             last
);

    localparam int unsigned CW = $clog2(WIDTH);

    logic [WIDTH-1:0] rem_q;
    logic [WIDTH-1:0] quo_q;
    logic [WIDTH-1:0] div_q;
    logic [CW-1:0]    cnt_q;
    logic             run_q;

    // Trial value is WIDTH+1 bits wide; the remainder kept is always < divisor.
    logic [WIDTH:0]   shifted;
    logic [WIDTH-1:0] diff;
    logic             fits;

    assign shifted = {rem_q, quo_q[WIDTH-1]};
    assign fits    = shifted >= {1'b0, div_q};
    assign diff    = shifted[WIDTH-1:0] - div_q;
    assign last    = run_q && (cnt_q == CW'(WIDTH - 1));
    assign q       = quo_q;
    assign r       = rem_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rem_q <= '0;
            quo_q <= '0;
            div_q <= '0;
            cnt_q <= '0;
            run_q <= 1'b0;
        end else if (load) begin
            rem_q <= '0;
            quo_q <= a;
            div_q <= b;
            cnt_q <= '0;
            run_q <= 1'b1;
        end else if (run_q) begin
            rem_q <= fits ? diff : shifted[WIDTH-1:0];
            quo_q <= {quo_q[WIDTH-2:0], fits};
            cnt_q <= cnt_q + 1'b1;
            if (last) begin
                run_q <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/peripheral_divn.sv
// peripheral_divn: memory-mapped WIDTH-bit integer divider (signed RISC-V DIV/REM or unsigned).
//   clk, reset : clock, asynchronous active-high reset
//   bus        : slave side of peripheral_divn_if (cs, addr, rd, wr, d_in -> d_out, irq)
//   Registers: DIVIDEND, DIVISOR, CTRL{irq_en,signed,start}, STATUS{ovf,div_zero,done,busy},
//   QUOTIENT, REMAINDER. d_out is registered with one cycle of latency.
module peripheral_divn
    import divn_pkg::*;
#(
    parameter int unsigned WIDTH     = 16,
    parameter bit          SIGNED_EN = 1'b1
) (
    input  logic               clk,
    input  logic               reset,
    peripheral_divn_if.slave   bus
);

    localparam logic [WIDTH-1:0] MIN_VAL  = {1'b1, {(WIDTH - 1){1'b0}}};
    localparam logic [WIDTH-1:0] ALL_ONES = '1;

    divn_state_e      state_q;
    logic [WIDTH-1:0] dividend_q, divisor_q, quotient_q, remainder_q;
    logic [WIDTH-1:0] op_a_q, op_b_q;
    logic             irq_en_q, signed_q, done_q, div_zero_q, ovf_q;
    logic             op_signed_q, neg_q_q, neg_r_q, spec_zero_q, spec_ovf_q;
    logic [31:0]      d_out_q;

    logic [2:0]       reg_sel;
    logic             wr_en, rd_en, accept, busy;
    logic             neg_a, neg_b, is_div_zero, is_ovf, core_load, core_last;
    logic [WIDTH-1:0] abs_a, abs_b, core_q, core_r, q_fix, r_fix;
    logic [31:0]      rd_data;
    logic             unused_bus;

    assign reg_sel = bus.addr[4:2];
    assign wr_en   = bus.cs & bus.wr;
    assign rd_en   = bus.cs & bus.rd;
    assign busy    = (state_q != StIdle);
    assign accept  = wr_en && (reg_sel == REG_CTRL) && bus.d_in[CTRL_START] && !busy;

    assign neg_a       = op_signed_q & op_a_q[WIDTH-1];
    assign neg_b       = op_signed_q & op_b_q[WIDTH-1];
    assign abs_a       = neg_a ? -op_a_q : op_a_q;
    assign abs_b       = neg_b ? -op_b_q : op_b_q;
    assign is_div_zero = (op_b_q == '0);
    assign is_ovf      = op_signed_q && (op_a_q == MIN_VAL) && (op_b_q == ALL_ONES);
    assign core_load   = (state_q == StPrep) && !is_div_zero && !is_ovf;
    assign q_fix       = neg_q_q ? -core_q : core_q;
    assign r_fix       = neg_r_q ? -core_r : core_r;

    assign bus.d_out = d_out_q;
    assign bus.irq   = done_q & irq_en_q;
    assign unused_bus = ^{bus.d_in, bus.addr[1:0]};

    divn_core #(
        .WIDTH (WIDTH)
    ) u_core (
        .clk   (clk),
        .reset (reset),
        .load  (core_load),
        .a     (abs_a),
        .b     (abs_b),
        .q     (core_q),
        .r     (core_r),
        .last  (core_last)
    );

    always_comb begin
        rd_data = '0;
        unique case (reg_sel)
            REG_DIVIDEND:  rd_data = 32'(dividend_q);
            REG_DIVISOR:   rd_data = 32'(divisor_q);
            REG_CTRL:      rd_data = {29'd0, irq_en_q, signed_q, 1'b0};
            REG_STATUS:    rd_data = {28'd0, ovf_q, div_zero_q, done_q, busy};
            REG_QUOTIENT:  rd_data = 32'(quotient_q);
            REG_REMAINDER: rd_data = 32'(remainder_q);
            default:       rd_data = '0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= StIdle;
            dividend_q  <= '0;
            divisor_q   <= '0;
            quotient_q  <= '0;
            remainder_q <= '0;
            op_a_q      <= '0;
            op_b_q      <= '0;
            irq_en_q    <= 1'b0;
            signed_q    <= 1'b0;
            done_q      <= 1'b0;
            div_zero_q  <= 1'b0;
            ovf_q       <= 1'b0;
            op_signed_q <= 1'b0;
            neg_q_q     <= 1'b0;
            neg_r_q     <= 1'b0;
            spec_zero_q <= 1'b0;
            spec_ovf_q  <= 1'b0;
            d_out_q     <= '0;
        end else begin
            // Read data is taken from pre-edge state, so rd+wr returns the old value.
            if (rd_en) begin
                d_out_q <= rd_data;
            end
            if (wr_en) begin
                unique case (reg_sel)
                    REG_DIVIDEND: dividend_q <= bus.d_in[WIDTH-1:0];
                    REG_DIVISOR:  divisor_q  <= bus.d_in[WIDTH-1:0];
                    REG_CTRL: begin
                        irq_en_q <= bus.d_in[CTRL_IRQ_EN];
                        signed_q <= SIGNED_EN && bus.d_in[CTRL_SIGNED];
                    end
                    default: ;
                endcase
            end
            // Cleared here, re-set below in FIX so that a same-edge completion wins.
            if (rd_en && (reg_sel == REG_QUOTIENT)) begin
                done_q <= 1'b0;
            end

            unique case (state_q)
                StIdle: begin
                    if (accept) begin
                        op_a_q      <= dividend_q;
                        op_b_q      <= divisor_q;
                        op_signed_q <= SIGNED_EN && bus.d_in[CTRL_SIGNED];
                        done_q      <= 1'b0;
                        div_zero_q  <= 1'b0;
                        ovf_q       <= 1'b0;
                        state_q     <= StPrep;
                    end
                end
                StPrep: begin
                    neg_q_q     <= neg_a ^ neg_b;
                    neg_r_q     <= neg_a;
                    spec_zero_q <= is_div_zero;
                    spec_ovf_q  <= is_ovf && !is_div_zero;
                    state_q     <= (is_div_zero || is_ovf) ? StFix : StIter;
                end
                StIter: begin
                    if (core_last) begin
                        state_q <= StFix;
                    end
                end
                StFix: begin
                    if (spec_zero_q) begin
                        quotient_q  <= ALL_ONES;
                        remainder_q <= op_a_q;
                    end else if (spec_ovf_q) begin
                        quotient_q  <= MIN_VAL;
                        remainder_q <= '0;
                    end else begin
                        quotient_q  <= q_fix;
                        remainder_q <= r_fix;
                    end
                    div_zero_q <= spec_zero_q;
                    ovf_q      <= spec_ovf_q;
                    done_q     <= 1'b1;
                    state_q    <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_peripheral_divn.sv
// tb_peripheral_divn: scoreboard bench for peripheral_divn at WIDTH=16 (directed), 8 and 32 (model).
module tb_peripheral_divn;
    import divn_pkg::*;

    typedef struct {
        string       name;
        logic [31:0] val;
        bit          chk_irq;
        logic        irq;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        cs = 1'b0, rd = 1'b0, wr = 1'b0;
    logic [4:0]  addr = '0;
    logic [31:0] d_in = '0;
    logic [1:0]  sel = 2'd0;   // 0: WIDTH=16, 1: WIDTH=8, 2: WIDTH=32
    logic [1:0]  sel_fire = 2'd0;
    logic        rd_fire = 1'b0;
    logic [31:0] mon_dout;
    logic        mon_irq;

    int n_cmp = 0;
    int n_fail = 0;
    exp_t sb[$];

    always #5 clk = ~clk;

    peripheral_divn_if bus16 ();
    peripheral_divn_if bus8 ();
    peripheral_divn_if bus32 ();

    assign bus16.cs = cs && (sel == 2'd0);
    assign bus8.cs  = cs && (sel == 2'd1);
    assign bus32.cs = cs && (sel == 2'd2);
    assign bus16.addr = addr;  assign bus8.addr = addr;  assign bus32.addr = addr;
    assign bus16.rd   = rd;    assign bus8.rd   = rd;    assign bus32.rd   = rd;
    assign bus16.wr   = wr;    assign bus8.wr   = wr;    assign bus32.wr   = wr;
    assign bus16.d_in = d_in;  assign bus8.d_in = d_in;  assign bus32.d_in = d_in;

    peripheral_divn #(.WIDTH(16), .SIGNED_EN(1'b1)) dut16 (
        .clk (clk), .reset (reset), .bus (bus16.slave));
    peripheral_divn #(.WIDTH(8), .SIGNED_EN(1'b1)) dut8 (
        .clk (clk), .reset (reset), .bus (bus8.slave));
    peripheral_divn #(.WIDTH(32), .SIGNED_EN(1'b1)) dut32 (
        .clk (clk), .reset (reset), .bus (bus32.slave));

    always_comb begin
        mon_dout = bus16.d_out;
        mon_irq  = bus16.irq;
        if (sel_fire == 2'd1) begin
            mon_dout = bus8.d_out;
            mon_irq  = bus8.irq;
        end else if (sel_fire == 2'd2) begin
            mon_dout = bus32.d_out;
            mon_irq  = bus32.irq;
        end
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, act, exp);
        end
    endtask

    // Monitor: a read sampled on a rising edge is visible on d_out by the next falling edge.
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_fire <= 1'b0;
        end else begin
            rd_fire  <= cs & rd;
            sel_fire <= sel;
        end
    end

    always @(negedge clk) begin
        if (rd_fire) begin
            if (sb.size() == 0) begin
                check("unexpected_read", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check(e.name, mon_dout, e.val);
                if (e.chk_irq) check({e.name, "_irq"}, 32'(mon_irq), 32'(e.irq));
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic bus_wr(input logic [2:0] r, input logic [31:0] d);
        addr = {r, 2'b00};
        d_in = d;
        cs = 1'b1;
        wr = 1'b1;
        @(negedge clk);
        cs = 1'b0;
        wr = 1'b0;
    endtask

    task automatic bus_rd(input logic [2:0] r, input string nm, input logic [31:0] exp,
                          input bit ci, input logic ei);
        exp_t e;
        e.name = nm; e.val = exp; e.chk_irq = ci; e.irq = ei;
        sb.push_back(e);
        addr = {r, 2'b00};
        cs = 1'b1;
        rd = 1'b1;
        @(negedge clk);
        cs = 1'b0;
        rd = 1'b0;
    endtask

    task automatic bus_rdwr(input logic [2:0] r, input logic [31:0] d, input string nm,
                            input logic [31:0] exp);
        exp_t e;
        e.name = nm; e.val = exp; e.chk_irq = 1'b0; e.irq = 1'b0;
        sb.push_back(e);
        addr = {r, 2'b00};
        d_in = d;
        cs = 1'b1; rd = 1'b1; wr = 1'b1;
        @(negedge clk);
        cs = 1'b0; rd = 1'b0; wr = 1'b0;
    endtask

    task automatic op16(input logic [31:0] a, input logic [31:0] b, input logic [31:0] ctrl,
                        input string nm, input logic [31:0] eq, input logic [31:0] er,
                        input logic [31:0] est);
        bus_wr(REG_DIVIDEND, a);
        bus_wr(REG_DIVISOR, b);
        bus_wr(REG_CTRL, ctrl);
        idle(20);
        bus_rd(REG_STATUS, {nm, "_status"}, est, 1'b0, 1'b0);
        bus_rd(REG_QUOTIENT, {nm, "_q"}, eq, 1'b0, 1'b0);
        bus_rd(REG_REMAINDER, {nm, "_r"}, er, 1'b0, 1'b0);
    endtask

    // Reference: RISC-V DIV/REM (or unsigned) on w-bit operands, computed in 64-bit arithmetic.
    function automatic void ref_div(input int w, input bit sg, input logic [31:0] a,
                                    input logic [31:0] b, output logic [31:0] q,
                                    output logic [31:0] r, output logic [31:0] st);
        longint mask, sa, sb, half;
        mask = (longint'(1) << w) - 1;
        half = longint'(1) << (w - 1);
        sa = longint'(a) & mask;
        sb = longint'(b) & mask;
        if (sb == 0) begin
            q = 32'(mask); r = 32'(sa); st = 32'h6;
        end else if (sg && sa == half && sb == mask) begin
            q = 32'(half); r = 32'd0; st = 32'hA;
        end else begin
            if (sg && sa >= half) sa = sa - (longint'(1) << w);
            if (sg && sb >= half) sb = sb - (longint'(1) << w);
            q = 32'((sa / sb) & mask);
            r = 32'((sa % sb) & mask);
            st = 32'h2;
        end
    endfunction

    task automatic sweep_op(input int w, input bit sg, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] eq, er, est;
        ref_div(w, sg, a, b, eq, er, est);
        bus_wr(REG_DIVIDEND, a);
        bus_wr(REG_DIVISOR, b);
        bus_wr(REG_CTRL, sg ? 32'h3 : 32'h1);
        idle(w + 6);
        bus_rd(REG_STATUS, $sformatf("w%0d_status", w), est, 1'b0, 1'b0);
        bus_rd(REG_QUOTIENT, $sformatf("w%0d_q_%0h_%0h", w, a, b), eq, 1'b0, 1'b0);
        bus_rd(REG_REMAINDER, $sformatf("w%0d_r_%0h_%0h", w, a, b), er, 1'b0, 1'b0);
    endtask

    initial begin
        logic [31:0] ra, rb, minv, onesv;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        idle(1);

        // Reset state
        for (int i = 0; i < 8; i++) begin
            bus_rd(3'(i), $sformatf("reset_reg%0d", i), 32'd0, 1'b1, 1'b0);
        end

        // Unsigned 1000/7 with exact busy/done timing
        bus_wr(REG_DIVIDEND, 32'd1000);
        bus_wr(REG_DIVISOR, 32'd7);
        bus_wr(REG_CTRL, 32'h1);
        idle(17);
        bus_rd(REG_STATUS, "u1000_busy_last", 32'h1, 1'b1, 1'b0);
        bus_rd(REG_STATUS, "u1000_done", 32'h2, 1'b1, 1'b0);
        bus_rd(REG_QUOTIENT, "u1000_q", 32'd142, 1'b0, 1'b0);
        bus_rd(REG_REMAINDER, "u1000_r", 32'd6, 1'b0, 1'b0);
        bus_rd(REG_STATUS, "done_cleared", 32'h0, 1'b0, 1'b0);
        bus_rd(REG_CTRL, "ctrl_start_reads0", 32'h0, 1'b0, 1'b0);

        // Register access corner cases
        bus_rdwr(REG_DIVIDEND, 32'h1111, "rdwr_old_value", 32'd1000);
        bus_rd(REG_DIVIDEND, "rdwr_new_value", 32'h1111, 1'b0, 1'b0);
        bus_wr(REG_DIVISOR, 32'hABCD_0005);
        bus_rd(REG_DIVISOR, "upper_bits_ignored", 32'h5, 1'b0, 1'b0);
        bus_wr(3'd6, 32'hFFFF_FFFF);
        bus_rd(3'd6, "reg6_reads0", 32'h0, 1'b0, 1'b0);
        bus_wr(REG_STATUS, 32'hF);
        bus_rd(REG_STATUS, "status_ro", 32'h0, 1'b0, 1'b0);

        // Signed
        op16(32'hFFF9, 32'd2, 32'h3, "s_m7_2", 32'hFFFD, 32'hFFFF, 32'h2);
        bus_rd(REG_CTRL, "ctrl_signed", 32'h2, 1'b0, 1'b0);
        op16(32'd7, 32'hFFFE, 32'h3, "s_7_m2", 32'hFFFD, 32'h1, 32'h2);

        // Divide by zero, 3-edge completion
        bus_wr(REG_DIVIDEND, 32'h1234);
        bus_wr(REG_DIVISOR, 32'h0);
        bus_wr(REG_CTRL, 32'h1);
        idle(1);
        bus_rd(REG_STATUS, "dz_busy", 32'h1, 1'b0, 1'b0);
        bus_rd(REG_STATUS, "dz_done", 32'h6, 1'b0, 1'b0);
        bus_rd(REG_QUOTIENT, "dz_q", 32'hFFFF, 1'b0, 1'b0);
        bus_rd(REG_REMAINDER, "dz_r", 32'h1234, 1'b0, 1'b0);

        // Signed overflow, then the same operands unsigned
        op16(32'h8000, 32'hFFFF, 32'h3, "s_ovf", 32'h8000, 32'h0, 32'hA);
        op16(32'h8000, 32'hFFFF, 32'h1, "u_8000", 32'h0, 32'h8000, 32'h2);

        // Start while busy is ignored; operand writes do not disturb the running op
        bus_wr(REG_DIVIDEND, 32'd1000);
        bus_wr(REG_DIVISOR, 32'd7);
        bus_wr(REG_CTRL, 32'h1);
        idle(5);
        bus_wr(REG_DIVIDEND, 32'd50);
        bus_wr(REG_DIVISOR, 32'd5);
        bus_wr(REG_CTRL, 32'h1);
        idle(10);
        bus_rd(REG_STATUS, "restart_ignored", 32'h2, 1'b0, 1'b0);
        bus_rd(REG_QUOTIENT, "restart_q", 32'd142, 1'b0, 1'b0);
        bus_rd(REG_REMAINDER, "restart_r", 32'd6, 1'b0, 1'b0);
        bus_rd(REG_DIVIDEND, "busy_write_kept", 32'd50, 1'b0, 1'b0);

        // Interrupt
        bus_wr(REG_DIVIDEND, 32'd100);
        bus_wr(REG_DIVISOR, 32'd9);
        bus_wr(REG_CTRL, 32'h5);
        idle(20);
        bus_rd(REG_STATUS, "irq_status", 32'h2, 1'b1, 1'b1);
        bus_rd(REG_CTRL, "irq_ctrl", 32'h4, 1'b1, 1'b1);
        bus_rd(REG_QUOTIENT, "irq_q", 32'd11, 1'b1, 1'b0);
        bus_rd(REG_REMAINDER, "irq_r", 32'd1, 1'b1, 1'b0);

        // Reset mid-ITER
        bus_wr(REG_DIVIDEND, 32'd1000);
        bus_wr(REG_DIVISOR, 32'd7);
        bus_wr(REG_CTRL, 32'h5);
        idle(5);
        reset = 1'b1;
        idle(1);
        reset = 1'b0;
        idle(1);
        for (int i = 0; i < 6; i++) begin
            bus_rd(3'(i), $sformatf("midreset_reg%0d", i), 32'd0, 1'b1, 1'b0);
        end

        // WIDTH=8 and WIDTH=32 against the reference model
        for (int w = 0; w < 2; w++) begin
            int wd;
            wd = (w == 0) ? 8 : 32;
            sel = (w == 0) ? 2'd1 : 2'd2;
            minv = 32'd1 << (wd - 1);
            onesv = (wd == 32) ? 32'hFFFF_FFFF : ((32'd1 << wd) - 32'd1);
            for (int i = 0; i < 8; i++) begin
                ra = $urandom;
                rb = $urandom;
                if (i == 0) rb = 32'd0;
                if (i == 1) begin ra = minv; rb = onesv; end
                if (i == 2) begin ra = minv; rb = onesv; end
                if (i == 5) rb = rb >> (wd / 2 + 4);
                sweep_op(wd, (i % 2) == 1, ra, rb);
            end
        end
        sel = 2'd0;

        idle(3);
        check("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
